avalon_fp_host: RTL

//  Avalon-MM initiator for the FP-adder register slave (A @0, B @1, result Z @2).

---
 rtl/avalon_fp_host_pkg.sv | 7 +
 rtl/avalon_fp_host_if.sv | 31 +++
 rtl/avalon_fp_host.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/avalon_fp_host_pkg.sv
// avalon_fp_host_pkg: shared FSM state type and FP-adder register map
package avalon_fp_host_pkg;
  typedef enum logic [2:0] {IDLE, WR_A, WR_B, WAIT, RD, RD_WAIT, RESP} state_t;
  localparam int REG_A = 0;
  localparam int REG_B = 1;
  localparam int REG_Z = 2;
endpackage

// File: rtl/avalon_fp_host_if.sv
// avalon_fp_host_if: command/response ports plus Avalon-MM initiator signals
interface avalon_fp_host_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic [15:0]       txn_count;
  logic              avm_chipselect;
  logic              avm_write;
  logic              avm_read;
  logic [ADDR_W-1:0] avm_address;
  logic [DATA_W-1:0] avm_writedata;
  logic [DATA_W-1:0] avm_readdata;
  logic              avm_waitrequest;
  modport master (
    input  cmd_valid, cmd_a, cmd_b, rsp_ready, avm_readdata, avm_waitrequest,
    output cmd_ready, rsp_valid, rsp_result, txn_count,
           avm_chipselect, avm_write, avm_read, avm_address, avm_writedata
  );
  modport slave (
    output cmd_valid, cmd_a, cmd_b, rsp_ready, avm_readdata, avm_waitrequest,
    input  cmd_ready, rsp_valid, rsp_result, txn_count,
           avm_chipselect, avm_write, avm_read, avm_address, avm_writedata
  );
endinterface

// File: rtl/avalon_fp_host.sv
// avalon_fp_host: writes A and B to the FP-adder slave, waits, reads Z back
module avalon_fp_host
  import avalon_fp_host_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 4,
  parameter int ADDR_A       = REG_A,
  parameter int ADDR_B       = REG_B,
  parameter int ADDR_Z       = REG_Z,
  parameter int ADD_LATENCY  = 4,
  parameter int READ_LATENCY = 1
) (
  input logic                clk,
  input logic                reset_n,
  avalon_fp_host_if.master   bus
);
  localparam int MAX_L = ADD_LATENCY > READ_LATENCY ? ADD_LATENCY : READ_LATENCY;
  localparam int CNT_W = $clog2(MAX_L + 1);
  localparam logic [CNT_W-1:0]  ADD_CNT = CNT_W'(ADD_LATENCY);
  localparam logic [CNT_W-1:0]  RD_CNT  = CNT_W'(READ_LATENCY);
  localparam logic [CNT_W-1:0]  ONE     = CNT_W'(1);
  localparam logic [ADDR_W-1:0] A_ADR   = ADDR_W'(ADDR_A);
  localparam logic [ADDR_W-1:0] B_ADR   = ADDR_W'(ADDR_B);
  localparam logic [ADDR_W-1:0] Z_ADR   = ADDR_W'(ADDR_Z);
  state_t            state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              cs_q, cs_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [15:0]       txn_count_q, txn_count_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept;
  assign accept = cs_q & (wr_q | rd_q) & ~bus.avm_waitrequest;
  // next-state and next-output logic; bus outputs are set one cycle ahead so they leave flops
  always_comb begin
    state_d      = state_q;
    cmd_ready_d  = cmd_ready_q;
    rsp_valid_d  = rsp_valid_q;
    cs_d         = cs_q;
    wr_d         = wr_q;
    rd_d         = rd_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rsp_result_d = rsp_result_q;
    b_d          = b_q;
    txn_count_d  = txn_count_q;
    cnt_d        = cnt_q;
    unique case (state_q)
      IDLE: if (bus.cmd_valid && cmd_ready_q) begin
        b_d         = bus.cmd_b;
        cmd_ready_d = 1'b0;
        cs_d        = 1'b1;
        wr_d        = 1'b1;
        addr_d      = A_ADR;
        wdata_d     = bus.cmd_a;
        state_d     = WR_A;
      end
      WR_A: if (accept) begin
        addr_d  = B_ADR;
        wdata_d = b_q;
        state_d = WR_B;
      end
      WR_B: if (accept) begin
        wr_d    = 1'b0;
        wdata_d = '0;
        if (ADD_LATENCY == 0) begin
          rd_d    = 1'b1;
          addr_d  = Z_ADR;
          state_d = RD;
        end else begin
          cs_d    = 1'b0;
          addr_d  = '0;
          cnt_d   = ADD_CNT;
          state_d = WAIT;
        end
      end
      WAIT: if (cnt_q == ONE) begin
        cs_d    = 1'b1;
        rd_d    = 1'b1;
        addr_d  = Z_ADR;
        state_d = RD;
      end else begin
        cnt_d = cnt_q - ONE;
      end
      RD: if (accept) begin
        cs_d    = 1'b0;
        rd_d    = 1'b0;
        addr_d  = '0;
        cnt_d   = RD_CNT;
        state_d = RD_WAIT;
      end
      RD_WAIT: if (cnt_q == ONE) begin
        rsp_result_d = bus.avm_readdata;
        rsp_valid_d  = 1'b1;
        txn_count_d  = txn_count_q + 16'd1;
        state_d      = RESP;
      end else begin
        cnt_d = cnt_q - ONE;
      end
      RESP: if (bus.rsp_ready) begin
        rsp_valid_d = 1'b0;
        cmd_ready_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and output registers; async reset abandons any in-flight transfer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cmd_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      cs_q         <= 1'b0;
      wr_q         <= 1'b0;
      rd_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rsp_result_q <= '0;
      b_q          <= '0;
      txn_count_q  <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      cs_q         <= cs_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rsp_result_q <= rsp_result_d;
      b_q          <= b_d;
      txn_count_q  <= txn_count_d;
      cnt_q        <= cnt_d;
    end
  end
  assign bus.cmd_ready      = cmd_ready_q;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_result     = rsp_result_q;
  assign bus.txn_count      = txn_count_q;
  assign bus.avm_chipselect = cs_q;
  assign bus.avm_write      = wr_q;
  assign bus.avm_read       = rd_q;
  assign bus.avm_address    = addr_q;
  assign bus.avm_writedata  = wdata_q;
endmodule
